sfx_event_queue: RTL and testbench

SFX_EVENT_QUEUE -- requirements
Module: sfx_event_queue

---
 rtl/sfx_event_queue.sv | 151 +++++++++++++++
 tb/tb_sfx_event_queue.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sfx_event_queue.sv
// sfx_event_queue: synchronizes hit inputs into prioritized sound events, queues them and plays them frame-timed; `define SFX_TEST_MODE_EN adds the self-test sequencer
module sfx_event_queue #(
   parameter int EAT_FRAMES = 8,
   parameter int DIE_FRAMES = 32,
   parameter int HIT_FRAMES = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic frame_end,
   input  logic sheep_dragon_hit,
   input  logic player_dragon_hit,
   input  logic sword_dragon_hit,
   input  logic test_mode,
   output logic eat_sound,
   output logic die_sound,
   output logic hit_sound,
   output logic busy,
   output logic overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
   localparam logic [5:0] EAT_N = 6'(EAT_FRAMES);
   localparam logic [5:0] HIT_N = 6'(HIT_FRAMES);
   localparam logic [5:0] DIE_N = 6'(DIE_FRAMES);
   typedef enum logic [1:0] {IDLE, ARM, PLAY} state_t;
   logic [2:0] raw, inj, psel;
   logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, rise_q, rise_d, pend_q, pend_d;
   logic [2:0] snd_q, snd_d;
   logic [1:0] pcode, head, code_q, code_d;
   logic [1:0] mem_q [FIFO_DEPTH];
   logic [1:0] mem_d [FIFO_DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [5:0] frm_q, frm_d;
   logic full, wr_en, pop, busy_q, busy_d, ovf_q, ovf_d;
   state_t state_q, state_d;
   // bit order everywhere: [2]=DIE, [1]=HIT, [0]=EAT
   assign raw = {player_dragon_hit, sword_dragon_hit, sheep_dragon_hit};
`ifdef SFX_TEST_MODE_EN
   logic tm1_q, tm1_d, tm2_q, tm2_d;
   logic [5:0] tcnt_q, tcnt_d;
   logic [1:0] step_q, step_d;
   // every 64th frame_end under test_mode injects EAT, then HIT, then DIE on the following frames
   always_comb begin
      tm1_d = test_mode;
      tm2_d = tm1_q;
      tcnt_d = tm2_q ? (frame_end ? tcnt_q + 6'd1 : tcnt_q) : 6'd0;
      inj = 3'b000;
      step_d = step_q;
      if (!tm2_q) step_d = 2'd0;
      else if (frame_end) begin
         if (step_q == 2'd1) begin inj = 3'b010; step_d = 2'd2; end
         else if (step_q == 2'd2) begin inj = 3'b100; step_d = 2'd0; end
         else if (tcnt_q == 6'd63) begin inj = 3'b001; step_d = 2'd1; end
      end
   end
   // test-mode synchronizer and sequencer state
   always_ff @(posedge clk) begin
      if (reset) begin
         tm1_q <= 1'b0;
         tm2_q <= 1'b0;
         tcnt_q <= 6'd0;
         step_q <= 2'd0;
      end else begin
         tm1_q <= tm1_d;
         tm2_q <= tm2_d;
         tcnt_q <= tcnt_d;
         step_q <= step_d;
      end
   end
`else
   logic tm_unused;
   assign tm_unused = test_mode;
   assign inj = 3'b000;
`endif
   // edge detect, priority push into the FIFO, and the IDLE/ARM/PLAY playback sequencing
   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
      prev_d = sync2_q;
      rise_d = sync2_q & ~prev_q;
      psel = pend_q[2] ? 3'b100 : pend_q[1] ? 3'b010 : {2'b00, pend_q[0]};
      pcode = pend_q[2] ? 2'd3 : pend_q[1] ? 2'd2 : 2'd1;
      full = cnt_q == FULL;
      wr_en = |pend_q && !full;
      pop = state_q == IDLE && cnt_q != '0;
      pend_d = (pend_q & ~psel) | rise_q | inj;
      ovf_d = |pend_q && full;
      mem_d = mem_q;
      if (wr_en) mem_d[wr_q] = pcode;
      wr_d = wr_en ? wr_q + AW'(1) : wr_q;
      rd_d = pop ? rd_q + AW'(1) : rd_q;
      cnt_d = cnt_q + CW'(wr_en) - CW'(pop);
      head = mem_q[rd_q];
      state_d = state_q;
      code_d = code_q;
      frm_d = frm_q;
      if (pop) begin
         code_d = head;
         frm_d = head == 2'd3 ? DIE_N : head == 2'd2 ? HIT_N : EAT_N;
         state_d = ARM;
      end else if (state_q == ARM && frame_end) state_d = PLAY;
      else if (state_q == PLAY && frame_end) begin
         frm_d = frm_q - 6'd1;
         state_d = frm_q == 6'd1 ? IDLE : PLAY;
      end
      busy_d = state_d != IDLE;
      snd_d = state_d == PLAY ? {code_d == 2'd3, code_d == 2'd2, code_d == 2'd1} : 3'b000;
   end
   // FIFO storage needs no reset: pointers and count define which entries are valid
   always_ff @(posedge clk) mem_q <= mem_d;
   // all control state, including the registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 3'b000;
         sync2_q <= 3'b000;
         prev_q <= 3'b000;
         rise_q <= 3'b000;
         pend_q <= 3'b000;
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
         state_q <= IDLE;
         code_q <= 2'd0;
         frm_q <= 6'd0;
         snd_q <= 3'b000;
         busy_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q <= prev_d;
         rise_q <= rise_d;
         pend_q <= pend_d;
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
         state_q <= state_d;
         code_q <= code_d;
         frm_q <= frm_d;
         snd_q <= snd_d;
         busy_q <= busy_d;
         ovf_q <= ovf_d;
      end
   end
   assign {die_sound, hit_sound, eat_sound} = snd_q;
   assign busy = busy_q;
   assign overflow = ovf_q;
endmodule

// File: tb/tb_sfx_event_queue.sv
// tb_sfx_event_queue: directed checks of sfx_event_queue timing, priority, overflow, reset and held-level behaviour
module tb_sfx_event_queue;
   localparam int FP = 100;
   logic clk = 0, reset = 1, frame_end = 0, sheep = 0, player = 0, sword = 0, test_mode = 0;
   logic eat_sound, die_sound, hit_sound, busy, overflow;
   logic [2:0] snd;
   logic [2:0] prev_snd = 3'b000;
   int tests = 0, fails = 0, cyc = 0, ovf_cnt = 0, multi_cnt = 0;
   int rises [3] = '{0, 0, 0};

   sfx_event_queue dut (
      .clk(clk), .reset(reset), .frame_end(frame_end),
      .sheep_dragon_hit(sheep), .player_dragon_hit(player), .sword_dragon_hit(sword),
      .test_mode(test_mode), .eat_sound(eat_sound), .die_sound(die_sound),
      .hit_sound(hit_sound), .busy(busy), .overflow(overflow)
   );

   assign snd = {die_sound, hit_sound, eat_sound};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // frame_end is sampled high exactly at edges whose index is a multiple of FP
   initial forever begin
      @(posedge clk);
      #2;
      frame_end = ((cyc + 1) % FP) == 0;
   end

   always @(posedge clk) begin
      if (overflow === 1'b1) ovf_cnt++;
      if (snd === 3'b011 || snd === 3'b101 || snd === 3'b110 || snd === 3'b111) multi_cnt++;
      for (int i = 0; i < 3; i++) if (snd[i] === 1'b1 && prev_snd[i] !== 1'b1) rises[i]++;
      prev_snd = snd;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic play_one(input int budget, output logic [2:0] which, output int wait_c,
                           output int len, output int start_edge, output int busy_low);
      which = 3'b000; len = 0; busy_low = 0; start_edge = -1;
      for (wait_c = 0; wait_c < budget; wait_c++) begin
         tick();
         if (snd !== 3'b000) break;
      end
      if (snd !== 3'b000) begin
         which = snd;
         start_edge = cyc;
         while (snd === which && len < 5000) begin
            len++;
            if (busy !== 1'b1) busy_low++;
            tick();
         end
      end
   endtask

   task automatic test_reset;
      reset = 1; sheep = 1; player = 1;
      repeat (3) tick();
      tests++; if (eat_sound !== 1'b0) begin fails++; $display("FAIL reset_eat: got %b want 0", eat_sound); end
      tests++; if (die_sound !== 1'b0) begin fails++; $display("FAIL reset_die: got %b want 0", die_sound); end
      tests++; if (hit_sound !== 1'b0) begin fails++; $display("FAIL reset_hit: got %b want 0", hit_sound); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b want 0", overflow); end
      reset = 0; sheep = 0; player = 0;
      repeat (20) tick();
      tests++; if ({snd, busy} !== 4'b0000) begin fails++; $display("FAIL post_reset_idle: got %b want 0000", {snd, busy}); end
   endtask

   task automatic test_single_eat;
      int t, w, len, st, bl;
      logic [2:0] wh;
      for (int i = 0; i < FP && cyc % FP != 94; i++) tick();
      t = cyc;
      sheep = 1;
      repeat (3) tick();
      sheep = 0;
      repeat (2) tick();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL latency_busy_early: got %b want 0", busy); end
      tick();
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL latency_busy_pop: got %b want 1", busy); end
      play_one(3 * FP, wh, w, len, st, bl);
      tests++; if (wh !== 3'b001) begin fails++; $display("FAIL single_which: got %b want 001", wh); end
      tests++; if (len != 8 * FP) begin fails++; $display("FAIL single_len: got %0d want %0d", len, 8 * FP); end
      tests++; if (st != t + 6 + FP) begin fails++; $display("FAIL single_start_edge: got %0d want %0d", st, t + 6 + FP); end
      tests++; if (bl != 0) begin fails++; $display("FAIL single_busy_during_play: got %0d low cycles want 0", bl); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_after: got %b want 0", busy); end
   endtask

   task automatic test_priority;
      int o0, w, len, st, bl;
      logic [2:0] wh;
      o0 = ovf_cnt;
      sheep = 1; sword = 1; player = 1;
      repeat (3) tick();
      sheep = 0; sword = 0; player = 0;
      play_one(2 * FP + 20, wh, w, len, st, bl);
      tests++; if (wh !== 3'b100) begin fails++; $display("FAIL prio_first: got %b want 100", wh); end
      tests++; if (len != 32 * FP) begin fails++; $display("FAIL prio_die_len: got %0d want %0d", len, 32 * FP); end
      play_one(2 * FP, wh, w, len, st, bl);
      tests++; if (wh !== 3'b010) begin fails++; $display("FAIL prio_second: got %b want 010", wh); end
      tests++; if (len != 12 * FP) begin fails++; $display("FAIL prio_hit_len: got %0d want %0d", len, 12 * FP); end
      tests++; if (w != FP - 1) begin fails++; $display("FAIL prio_gap1: got %0d want %0d", w, FP - 1); end
      play_one(2 * FP, wh, w, len, st, bl);
      tests++; if (wh !== 3'b001) begin fails++; $display("FAIL prio_third: got %b want 001", wh); end
      tests++; if (len != 8 * FP) begin fails++; $display("FAIL prio_eat_len: got %0d want %0d", len, 8 * FP); end
      tests++; if (w != FP - 1) begin fails++; $display("FAIL prio_gap2: got %0d want %0d", w, FP - 1); end
      tests++; if (ovf_cnt != o0) begin fails++; $display("FAIL prio_overflow: got %0d pulses want 0", ovf_cnt - o0); end
   endtask

   task automatic test_overflow;
      int o0, w, len, st, bl, q;
      logic [2:0] wh;
      o0 = ovf_cnt;
      player = 1;
      repeat (3) tick();
      player = 0;
      for (int i = 0; i < 2 * FP + 20 && die_sound !== 1'b1; i++) tick();
      tests++; if (die_sound !== 1'b1) begin fails++; $display("FAIL ovf_die_start: got %b want 1", die_sound); end
      repeat (6) begin
         sword = 1;
         repeat (3) tick();
         sword = 0;
         repeat (7) tick();
      end
      tests++; if (ovf_cnt - o0 != 2) begin fails++; $display("FAIL ovf_pulses: got %0d want 2", ovf_cnt - o0); end
      for (int i = 0; i < 40 * FP && die_sound === 1'b1; i++) tick();
      tests++; if (die_sound !== 1'b0) begin fails++; $display("FAIL ovf_die_end: got %b want 0", die_sound); end
      for (int k = 0; k < 4; k++) begin
         play_one(2 * FP, wh, w, len, st, bl);
         tests++; if (wh !== 3'b010 || len != 12 * FP) begin fails++; $display("FAIL ovf_hit%0d: got which %b len %0d want 010 len %0d", k, wh, len, 12 * FP); end
      end
      q = 0;
      repeat (3 * FP) begin tick(); if (snd !== 3'b000) q++; end
      tests++; if (q != 0) begin fails++; $display("FAIL ovf_extra_sound: got %0d active cycles want 0", q); end
      tests++; if (ovf_cnt - o0 != 2) begin fails++; $display("FAIL ovf_pulses_final: got %0d want 2", ovf_cnt - o0); end
   endtask

   task automatic test_reset_mid_play;
      int q;
      player = 1;
      repeat (3) tick();
      player = 0;
      for (int i = 0; i < 2 * FP + 20 && die_sound !== 1'b1; i++) tick();
      sheep = 1;
      repeat (3) tick();
      sheep = 0;
      repeat (5 * FP - 3) tick();
      tests++; if (die_sound !== 1'b1) begin fails++; $display("FAIL midreset_playing: got %b want 1", die_sound); end
      reset = 1;
      tick();
      reset = 0;
      tests++; if (die_sound !== 1'b0) begin fails++; $display("FAIL midreset_die_drop: got %b want 0", die_sound); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b want 0", busy); end
      q = 0;
      repeat (3 * FP) begin tick(); if (snd !== 3'b000 || busy !== 1'b0) q++; end
      tests++; if (q != 0) begin fails++; $display("FAIL midreset_no_sound: got %0d active cycles want 0", q); end
   endtask

   task automatic test_held_level;
      int r0, r1, r2;
      r0 = rises[0]; r1 = rises[1]; r2 = rises[2];
      sheep = 1;
      repeat (1000) tick();
      sheep = 0;
      repeat (15 * FP) tick();
      tests++; if (rises[0] - r0 != 1) begin fails++; $display("FAIL held_eat_count: got %0d want 1", rises[0] - r0); end
      tests++; if (rises[1] != r1 || rises[2] != r2) begin fails++; $display("FAIL held_other: got hit %0d die %0d want 0 0", rises[1] - r1, rises[2] - r2); end
      tests++; if (snd !== 3'b000) begin fails++; $display("FAIL held_idle: got %b want 000", snd); end
   endtask

   task automatic test_test_mode;
      int r0, r1, r2, exp_n, hold, drain;
`ifdef SFX_TEST_MODE_EN
      exp_n = 2; hold = 132 * FP; drain = 70 * FP;
`else
      exp_n = 0; hold = 130 * FP; drain = 2 * FP;
`endif
      r0 = rises[0]; r1 = rises[1]; r2 = rises[2];
      test_mode = 1;
      repeat (hold) tick();
      test_mode = 0;
      repeat (drain) tick();
      tests++; if (rises[0] - r0 != exp_n) begin fails++; $display("FAIL tmode_eat: got %0d want %0d", rises[0] - r0, exp_n); end
      tests++; if (rises[1] - r1 != exp_n) begin fails++; $display("FAIL tmode_hit: got %0d want %0d", rises[1] - r1, exp_n); end
      tests++; if (rises[2] - r2 != exp_n) begin fails++; $display("FAIL tmode_die: got %0d want %0d", rises[2] - r2, exp_n); end
      tests++; if (snd !== 3'b000) begin fails++; $display("FAIL tmode_idle: got %b want 000", snd); end
   endtask

   initial begin
      test_reset();
      test_single_eat();
      test_priority();
      test_overflow();
      test_reset_mid_play();
      test_held_level();
      test_test_mode();
      tests++; if (multi_cnt != 0) begin fails++; $display("FAIL one_hot_triggers: got %0d multi-high cycles want 0", multi_cnt); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
